// File: rtl/gnw_key_matrix_if.sv
// Configuration bus for gnw_key_matrix.
// The core's loader drives entries from the game image's configuration
// section into the key-mapping table, one entry per clock.
interface gnw_key_matrix_if;
    logic       cfg_we;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_data;

    // Loader side: produces table writes.
    modport master (
        output cfg_we,
        output cfg_addr,
        output cfg_data
    );

    // Key matrix side: consumes table writes.
    modport slave (
        input cfg_we,
        input cfg_addr,
        input cfg_data
    );
endinterface

// File: rtl/gnw_key_matrix.sv
// gnw_key_matrix: maps debounced MiSTer joystick bits onto the K input lines
// of an LCD-game MCU according to a run-time loaded table indexed by
// (strobe, key). Several active strobes combine as a wired-OR matrix, and K
// can be presented active-low.
//
// Pipeline:
//   joy -> 2-flop synchroniser -> debounce -> joy_db --+
//   S   -> s_p0 ---------------------------------------+-> key lookup -> K
//   cfg -> table registers ----------------------------+
module gnw_key_matrix #(
    parameter int NUM_STROBES     = 8,
    parameter int KEYS_PER_STROBE = 4,
    parameter int JOY_WIDTH       = 32,
    parameter int DEB_BITS        = 4,
    parameter bit K_INVERT        = 1'b0
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    input  logic [JOY_WIDTH-1:0]       joy,
    input  logic [NUM_STROBES-1:0]     S,
    gnw_key_matrix_if.slave            cfg,
    output logic [KEYS_PER_STROBE-1:0] K,
    output logic [JOY_WIDTH-1:0]       joy_db
);

    localparam int TBL_SIZE = NUM_STROBES * KEYS_PER_STROBE;

    // Idle level of K: no key pressed, taking the output polarity into account.
    localparam logic [KEYS_PER_STROBE-1:0] K_IDLE = {KEYS_PER_STROBE{K_INVERT}};

    // A table entry selects a joystick bit only when its mapped flag is set
    // and the index points at an existing joystick bit.
    function automatic logic entry_mapped(input logic [7:0] entry);
        return entry[7] && (int'(entry[6:0]) < JOY_WIDTH);
    endfunction

    // Joystick bits widened to the full 7-bit index space so any entry index
    // selects a defined bit; bits beyond JOY_WIDTH read as released.
    function automatic logic entry_hit(input logic [7:0]   entry,
                                       input logic [127:0] joy_pad);
        return entry_mapped(entry) && joy_pad[entry[6:0]];
    endfunction

    logic [JOY_WIDTH-1:0]       joy_sync_p0;
    logic [JOY_WIDTH-1:0]       joy_sync_p1;
    logic [DEB_BITS-1:0]        deb_cnt [JOY_WIDTH];
    logic [7:0]                 tbl [TBL_SIZE];
    logic [NUM_STROBES-1:0]     s_p0;
    logic [127:0]               joy_pad;
    logic [KEYS_PER_STROBE-1:0] key_comb;

    // ---- stage: joystick synchroniser (joy is asynchronous to clk_sys) ----
    // Two-flop synchroniser, one per joystick bit.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            joy_sync_p0 <= '0;
            joy_sync_p1 <= '0;
        end else begin
            joy_sync_p0 <= joy;
            joy_sync_p1 <= joy_sync_p0;
        end
    end

    // ---- stage: debounce ----
    // Per-bit debounce: a new level must persist for 2^DEB_BITS cycles before
    // joy_db follows. Any return to the current joy_db level restarts the
    // count, so short glitches are discarded entirely. The counter clears on
    // toggle and therefore never wraps.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            joy_db <= '0;
            for (int i = 0; i < JOY_WIDTH; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < JOY_WIDTH; i++) begin
                if (joy_sync_p1[i] == joy_db[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == {DEB_BITS{1'b1}}) begin
                    joy_db[i]  <= ~joy_db[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Key-mapping table. Addresses past the end of the table match no entry,
    // so such writes leave the table untouched. Writes while the MCU is
    // scanning are allowed; the K lookup below sees the pre-edge contents.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int e = 0; e < TBL_SIZE; e++) begin
                tbl[e] <= 8'h00;
            end
        end else begin
            for (int e = 0; e < TBL_SIZE; e++) begin
                if (cfg.cfg_we && (cfg.cfg_addr == 8'(e))) begin
                    tbl[e] <= cfg.cfg_data;
                end
            end
        end
    end

    // ---- stage: strobe capture ----
    // Register the MCU strobes so the lookup works from a stable copy.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            s_p0 <= '0;
        end else begin
            s_p0 <= S;
        end
    end

    assign joy_pad = 128'(joy_db);

    // Wired-OR matrix: a key line is pressed when any active strobe has a
    // mapped entry for that key whose joystick bit is pressed.
    always_comb begin
        key_comb = '0;
        for (int s = 0; s < NUM_STROBES; s++) begin
            for (int k = 0; k < KEYS_PER_STROBE; k++) begin
                if (s_p0[s] && entry_hit(tbl[s*KEYS_PER_STROBE + k], joy_pad)) begin
                    key_comb[k] = 1'b1;
                end
            end
        end
    end

    // ---- stage: K output register ----
    // Registered K with the selected polarity.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            K <= K_IDLE;
        end else begin
            K <= key_comb ^ K_IDLE;
        end
    end

endmodule

// File: tb/tb_gnw_key_matrix.sv
// Testbench for gnw_key_matrix: directed stimulus with a cycle-stamped
// scoreboard. Stimulus pushes expected K / joy_db values tagged with the
// clock cycle at which they must appear; a monitor on the falling edge
// compares every entry due in the current cycle.
module tb_gnw_key_matrix;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [31:0] joy;
    logic [7:0]  S;
    logic [3:0]  K0, K1;
    logic [31:0] jdb0, jdb1;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        bit          is_k;
        bit          inst;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];

    gnw_key_matrix_if cfg_if();

    gnw_key_matrix #(
        .NUM_STROBES(8), .KEYS_PER_STROBE(4), .JOY_WIDTH(32),
        .DEB_BITS(4), .K_INVERT(1'b0)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .joy(joy), .S(S),
        .cfg(cfg_if.slave), .K(K0), .joy_db(jdb0)
    );

    gnw_key_matrix #(
        .NUM_STROBES(8), .KEYS_PER_STROBE(4), .JOY_WIDTH(32),
        .DEB_BITS(4), .K_INVERT(1'b1)
    ) dut_inv (
        .clk_sys(clk_sys), .reset_n(reset_n), .joy(joy), .S(S),
        .cfg(cfg_if.slave), .K(K1), .joy_db(jdb1)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Monitor: compare every expectation due in this cycle.
    always @(negedge clk_sys) begin
        int i;
        logic [31:0] act;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                if (sb[i].is_k) act = sb[i].inst ? {28'b0, K1} : {28'b0, K0};
                else            act = sb[i].inst ? jdb1 : jdb0;
                checks++;
                if (act !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", sb[i].name, cyc, act, sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s missed cyc=%0d got=none exp=%h", sb[i].name, sb[i].cyc, sb[i].val);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic push(input string nm, input int off, input bit is_k,
                        input bit inst, input logic [31:0] v);
        exp_t e;
        e.cyc  = cyc + off;
        e.is_k = is_k;
        e.inst = inst;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Expected key state k: plain instance shows k, inverted instance ~k.
    task automatic exp_k(input string nm, input int off, input logic [3:0] k);
        logic [3:0] kn;
        kn = ~k;
        push(nm, off, 1'b1, 1'b0, {28'b0, k});
        push({nm, "_inv"}, off, 1'b1, 1'b1, {28'b0, kn});
    endtask

    task automatic exp_jdb(input string nm, input int off, input logic [31:0] v);
        push(nm, off, 1'b0, 1'b0, v);
    endtask

    // One table write; returns just after the committing edge.
    task automatic cfg_write(input logic [7:0] addr, input logic [7:0] data);
        cfg_if.cfg_we   = 1'b1;
        cfg_if.cfg_addr = addr;
        cfg_if.cfg_data = data;
        tick(1);
        cfg_if.cfg_we   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        joy = '0;
        S = '0;
        cfg_if.cfg_we = 1'b0;
        cfg_if.cfg_addr = '0;
        cfg_if.cfg_data = '0;

        // Reset values
        tick(3);
        exp_k("rst_k", 0, 4'h0);
        exp_jdb("rst_jdb", 0, 32'h0);
        tick(1);
        reset_n = 1'b1;
        tick(2);

        // Single-strobe mapping
        cfg_write(8'd0, 8'h80);
        cfg_write(8'd5, 8'h84);
        joy = 32'h1;
        tick(40);
        exp_jdb("hold_jdb", 0, 32'h1);
        S = 8'h01;
        exp_k("s1_early", 1, 4'b0000);
        exp_k("s1_k", 2, 4'b0001);
        tick(3);
        joy = 32'h11;
        tick(20);
        S = 8'h02;
        exp_k("s2_early", 1, 4'b0001);
        exp_k("s2_k", 2, 4'b0010);
        tick(3);

        // Wired-OR of two strobes onto key 0
        cfg_write(8'd0, 8'h81);
        cfg_write(8'd4, 8'h82);
        joy = 32'h4;
        tick(20);
        exp_jdb("wor_jdb", 0, 32'h4);
        S = 8'h03;
        exp_k("wor_k", 2, 4'b0001);
        tick(3);
        S = 8'h00;
        exp_k("s0_early", 1, 4'b0001);
        exp_k("s0_k", 2, 4'b0000);
        tick(3);

        // Debounce: short pulse rejected, long pulse accepted
        cfg_write(8'd4, 8'h00);
        cfg_write(8'd0, 8'h80);
        joy = 32'h0;
        tick(20);
        S = 8'h01;
        tick(3);
        joy = 32'h1;
        exp_jdb("glitch_jdb5", 5, 32'h0);
        exp_jdb("glitch_jdb12", 12, 32'h0);
        exp_jdb("glitch_jdb18", 18, 32'h0);
        exp_jdb("glitch_jdb20", 20, 32'h0);
        exp_k("glitch_k19", 19, 4'b0000);
        exp_k("glitch_k21", 21, 4'b0000);
        tick(10);
        joy = 32'h0;
        tick(20);
        joy = 32'h1;
        exp_jdb("deb_jdb17", 17, 32'h0);
        exp_jdb("deb_jdb18", 18, 32'h1);
        exp_k("deb_k18", 18, 4'b0000);
        exp_k("deb_k19", 19, 4'b0001);
        exp_jdb("deb_fall37", 37, 32'h1);
        exp_jdb("deb_fall38", 38, 32'h0);
        exp_k("deb_kfall38", 38, 4'b0001);
        exp_k("deb_kfall39", 39, 4'b0000);
        tick(20);
        joy = 32'h0;
        tick(25);

        // Illegal entries
        joy = 32'hFFFF_FFFF;
        tick(20);
        exp_k("ill_base", 0, 4'b0001);
        cfg_write(8'd32, 8'h00);
        exp_k("ill_oor1", 1, 4'b0001);
        exp_k("ill_oor2", 2, 4'b0001);
        tick(2);
        cfg_write(8'd0, 8'hA5);
        exp_k("ill_idx0", 0, 4'b0001);
        exp_k("ill_idx1", 1, 4'b0000);
        cfg_write(8'd0, 8'h80);
        exp_k("ill_remap", 1, 4'b0001);
        cfg_write(8'd0, 8'h05);
        exp_k("ill_nomap", 1, 4'b0000);
        tick(2);

        // Live rewrite with strobe 0 active
        cfg_write(8'd0, 8'h83);
        exp_k("live0", 0, 4'b0000);
        exp_k("live1", 1, 4'b0001);
        tick(3);

        // Reset mid-run: immediate, and the table is cleared
        reset_n = 1'b0;
        exp_k("mid_rst_k", 0, 4'h0);
        exp_jdb("mid_rst_jdb", 0, 32'h0);
        tick(2);
        exp_k("mid_rst_hold", 0, 4'h0);
        reset_n = 1'b1;
        tick(25);
        exp_jdb("post_rst_jdb", 0, 32'hFFFF_FFFF);
        exp_k("post_rst_k", 0, 4'h0);
        tick(2);

        for (int t = 0; t < 50 && sb.size() != 0; t++) tick(1);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got=%0d exp=0 pending", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
